// File: rtl/dmem_responder.sv
// Data-memory responder: load/store slave with fixed wait states, lane alignment and extension.
module dmem_responder #(
  parameter logic [31:0] DMEM_BASE   = 32'h0010_0000,
  parameter int unsigned DMEM_SIZE   = 32768,
  parameter string       INIT_FILE   = "target/data.mif",
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_read_status,
  input  logic [1:0]  req_write_status,
  input  logic        req_load_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned AW        = $clog2(DMEM_SIZE);
  localparam int unsigned WORDS     = DMEM_SIZE / 4;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  rd_q, rd_d;
  logic [1:0]  wr_q, wr_d;
  logic        sgn_q, sgn_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  cur_rd, cur_wr, acc_status;
  logic        cur_sgn;
  logic [2:0]  acc_size;
  logic [31:0] offset;
  logic [32:0] end_off;
  logic        in_range, misaligned, dec_err;
  logic [AW-3:0] word_idx;
  logic [31:0] rd_word, load_val, wr_lanes;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  be;
  logic        commit, do_write;

  logic [31:0] mem [WORDS];

  // With zero wait states the commit edge is the accept edge, so decode looks at the live request in IDLE.
  always_comb begin
    cur_addr  = (state_q == ST_IDLE) ? req_addr         : addr_q;
    cur_rd    = (state_q == ST_IDLE) ? req_read_status  : rd_q;
    cur_wr    = (state_q == ST_IDLE) ? req_write_status : wr_q;
    cur_sgn   = (state_q == ST_IDLE) ? req_load_signed  : sgn_q;
    cur_wdata = (state_q == ST_IDLE) ? req_wdata        : wdata_q;

    acc_status = (cur_rd != 2'b00) ? cur_rd : cur_wr;
    case (acc_status)
      2'b01:   acc_size = 3'd1;
      2'b10:   acc_size = 3'd2;
      default: acc_size = 3'd4;
    endcase

    offset     = cur_addr - DMEM_BASE;
    end_off    = {1'b0, offset} + {30'b0, acc_size};
    in_range   = (cur_addr >= DMEM_BASE) && (end_off <= 33'(DMEM_SIZE));
    misaligned = ((acc_status == 2'b10) && cur_addr[0]) ||
                 ((acc_status == 2'b11) && (cur_addr[1:0] != 2'b00));
    dec_err    = ((cur_rd != 2'b00) && (cur_wr != 2'b00)) || misaligned || !in_range;
    word_idx   = offset[AW-1:2];
  end

  // Load lane extraction and extension; store lane replication and byte enables.
  always_comb begin
    rd_word  = mem[word_idx];
    byte_v   = rd_word[{cur_addr[1:0], 3'b000} +: 8];
    half_v   = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = 32'h0;
    case (cur_rd)
      2'b01:   load_val = {{24{cur_sgn & byte_v[7]}}, byte_v};
      2'b10:   load_val = {{16{cur_sgn & half_v[15]}}, half_v};
      2'b11:   load_val = rd_word;
      default: load_val = 32'h0;
    endcase

    be       = 4'b0000;
    wr_lanes = cur_wdata;
    case (cur_wr)
      2'b01: begin
        be       = 4'b0001 << cur_addr[1:0];
        wr_lanes = {4{cur_wdata[7:0]}};
      end
      2'b10: begin
        be       = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{cur_wdata[15:0]}};
      end
      2'b11:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ((req_read_status != 2'b00) || (req_write_status != 2'b00))) begin
          addr_d  = req_addr;
          rd_d    = req_read_status;
          wr_d    = req_write_status;
          sgn_d   = req_load_signed;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'd0;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      err_d   = dec_err;
      rdata_d = (dec_err || (cur_rd == 2'b00)) ? 32'h0 : load_val;
    end
  end

  assign do_write = commit && !dec_err && (cur_wr != 2'b00);

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      rd_q    <= 2'b00;
      wr_q    <= 2'b00;
      sgn_q   <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the RAM array has no reset; reset only suppresses a write that would land on the same edge.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: byte-level memory model, response queue, literal pins.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int          SIZE = 32768;
  localparam int          W    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_read_status;
  logic [1:0]  req_write_status;
  logic        req_load_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  dmem_responder #(
    .DMEM_BASE  (BASE),
    .DMEM_SIZE  (SIZE),
    .WAIT_CYCLES(W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_read_status (req_read_status),
    .req_write_status(req_write_status),
    .req_load_signed (req_load_signed),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_error      (resp_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  int          n_vec = 0;
  int          n_err = 0;
  resp_t       exp_q[$];
  logic [7:0]  mdl [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-addressed reference memory: applies the access rules directly.
  function automatic resp_t model_access(input logic [31:0] a, input logic [1:0] rd,
                                         input logic [1:0] wr, input logic sgn,
                                         input logic [31:0] wd);
    resp_t      r;
    logic [1:0] st;
    int         sz;
    longint     last;
    st   = (rd != 2'b00) ? rd : wr;
    sz   = (st == 2'b01) ? 1 : (st == 2'b10) ? 2 : 4;
    last = longint'({32'h0, a}) - longint'({32'h0, BASE}) + longint'(sz);
    r.err   = ((rd != 2'b00) && (wr != 2'b00)) || ((a % sz) != 0) || (a < BASE) || (last > SIZE);
    r.rdata = 32'h0;
    if (!r.err) begin
      if (wr != 2'b00) begin
        for (int i = 0; i < sz; i++) mdl[a + 32'(i)] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) r.rdata = r.rdata | (32'(mdl[a + 32'(i)]) << (8*i));
        if (sgn && (sz < 4) && r.rdata[8*sz-1]) r.rdata = r.rdata | ~((32'd1 << (8*sz)) - 32'd1);
      end
    end
    return r;
  endfunction

  // Every cycle a response is presented it must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {31'h0, resp_valid}, 32'h0);
      end else begin
        check("resp_rdata", resp_rdata, exp_q[0].rdata);
        check("resp_error", {31'h0, resp_error}, {31'h0, exp_q[0].err});
      end
      check("req_ready_busy", {31'h0, req_ready}, 32'h0);
    end
  end

  task automatic issue(input logic [31:0] a, input logic [1:0] rd, input logic [1:0] wr,
                       input logic sgn, input logic [31:0] wd, input bit expect_resp);
    @(posedge clk);
    #1;
    req_valid        = 1'b1;
    req_addr         = a;
    req_read_status  = rd;
    req_write_status = wr;
    req_load_signed  = sgn;
    req_wdata        = wd;
    @(negedge clk);
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    if (expect_resp) exp_q.push_back(model_access(a, rd, wr, sgn, wd));
    #1;
    req_valid        = 1'b0;
    req_read_status  = 2'b00;
    req_write_status = 2'b00;
  endtask

  task automatic wait_resp(output logic [31:0] rdat, output logic err);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    check("latency", 32'(lat), 32'(W + 1));
    check("resp_seen", {31'h0, resp_valid}, 32'h1);
    rdat = resp_rdata;
    err  = resp_error;
  endtask

  task automatic finish_resp(input int hold);
    repeat (hold) @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    check("resp_valid_drop", {31'h0, resp_valid}, 32'h0);
    check("req_ready_back", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic do_txn(input logic [31:0] a, input logic [1:0] rd, input logic [1:0] wr,
                        input logic sgn, input logic [31:0] wd, input int hold,
                        output logic [31:0] rdat, output logic err);
    issue(a, rd, wr, sgn, wd, 1'b1);
    wait_resp(rdat, err);
    finish_resp(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_v;
    logic        er_v;

    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_read_status = 2'b00;
    req_write_status = 2'b00; req_load_signed = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_error", {31'h0, resp_error}, 32'h0);

    // Word store then load.
    do_txn(BASE + 32'h10, 2'b00, 2'b11, 1'b0, 32'hDEAD_BEEF, 0, rd_v, er_v);
    check("st_word_err", {31'h0, er_v}, 32'h0);
    do_txn(BASE + 32'h10, 2'b11, 2'b00, 1'b0, 32'h0, 0, rd_v, er_v);
    check("lit_word", rd_v, 32'hDEAD_BEEF);

    // Byte-enable store over a known word, then word/byte/half loads.
    do_txn(BASE + 32'h10, 2'b00, 2'b11, 1'b0, 32'h1122_3344, 0, rd_v, er_v);
    do_txn(BASE + 32'h13, 2'b00, 2'b01, 1'b0, 32'hFFFF_FF80, 0, rd_v, er_v);
    do_txn(BASE + 32'h10, 2'b11, 2'b00, 1'b0, 32'h0, 0, rd_v, er_v);
    check("lit_byte_merge", rd_v, 32'h8022_3344);
    do_txn(BASE + 32'h13, 2'b01, 2'b00, 1'b1, 32'h0, 0, rd_v, er_v);
    check("lit_lb_signed", rd_v, 32'hFFFF_FF80);
    do_txn(BASE + 32'h13, 2'b01, 2'b00, 1'b0, 32'h0, 0, rd_v, er_v);
    check("lit_lb_unsigned", rd_v, 32'h0000_0080);
    do_txn(BASE + 32'h12, 2'b10, 2'b00, 1'b1, 32'h0, 0, rd_v, er_v);
    check("lit_lh_signed", rd_v, 32'hFFFF_8022);
    do_txn(BASE + 32'h10, 2'b10, 2'b00, 1'b1, 32'h0, 0, rd_v, er_v);
    check("lit_lh_low", rd_v, 32'h0000_3344);

    // Misalignment leaves RAM untouched.
    do_txn(BASE + 32'h0, 2'b00, 2'b11, 1'b0, 32'hA5A5_5A5A, 0, rd_v, er_v);
    do_txn(BASE + 32'h1, 2'b10, 2'b00, 1'b0, 32'h0, 0, rd_v, er_v);
    check("lit_mis_half", {er_v, rd_v[30:0]}, 32'h8000_0000);
    do_txn(BASE + 32'h2, 2'b00, 2'b11, 1'b0, 32'hFFFF_FFFF, 0, rd_v, er_v);
    check("lit_mis_word_err", {31'h0, er_v}, 32'h1);
    do_txn(BASE + 32'h0, 2'b11, 2'b00, 1'b0, 32'h0, 0, rd_v, er_v);
    check("lit_mis_unchanged", rd_v, 32'hA5A5_5A5A);

    // Both statuses set: error, no write.
    do_txn(BASE + 32'h10, 2'b11, 2'b11, 1'b0, 32'h0, 0, rd_v, er_v);
    check("lit_both_err", {31'h0, er_v}, 32'h1);

    // Range boundaries.
    do_txn(32'h000F_FFFC, 2'b11, 2'b00, 1'b0, 32'h0, 0, rd_v, er_v);
    check("lit_below_base", {31'h0, er_v}, 32'h1);
    do_txn(BASE + SIZE, 2'b11, 2'b00, 1'b0, 32'h0, 0, rd_v, er_v);
    check("lit_past_end", {31'h0, er_v}, 32'h1);
    do_txn(BASE + SIZE, 2'b00, 2'b01, 1'b0, 32'h55, 0, rd_v, er_v);
    do_txn(BASE + SIZE - 4, 2'b00, 2'b11, 1'b0, 32'h1357_9BDF, 0, rd_v, er_v);
    do_txn(BASE + SIZE - 4, 2'b11, 2'b00, 1'b0, 32'h0, 0, rd_v, er_v);
    check("lit_last_word", rd_v, 32'h1357_9BDF);
    check("lit_last_word_err", {31'h0, er_v}, 32'h0);
    do_txn(BASE + SIZE - 1, 2'b01, 2'b00, 1'b1, 32'h0, 0, rd_v, er_v);
    check("lit_last_byte", rd_v, 32'h0000_0013);

    // Backpressure with a second request held pending.
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_addr = BASE + 32'h10; req_read_status = 2'b11;
    req_write_status = 2'b00; req_load_signed = 1'b0;
    @(posedge clk);
    exp_q.push_back(model_access(BASE + 32'h10, 2'b11, 2'b00, 1'b0, 32'h0));
    #1;
    req_addr = BASE + 32'h11; req_read_status = 2'b01;
    wait_resp(rd_v, er_v);
    check("lit_bp_word", rd_v, 32'h8022_3344);
    repeat (5) @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    check("bp_resp_drop", {31'h0, resp_valid}, 32'h0);
    check("bp_ready_after_hs", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    exp_q.push_back(model_access(BASE + 32'h11, 2'b01, 2'b00, 1'b0, 32'h0));
    #1;
    req_valid = 1'b0; req_read_status = 2'b00;
    wait_resp(rd_v, er_v);
    check("lit_bp_second", rd_v, 32'h0000_0033);
    finish_resp(0);

    // No-op request is ignored.
    @(posedge clk);
    #1 req_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("noop_ready", {31'h0, req_ready}, 32'h1);
      check("noop_no_resp", {31'h0, resp_valid}, 32'h0);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;

    // Reset aborts an in-flight store.
    do_txn(BASE + 32'h20, 2'b00, 2'b11, 1'b0, 32'h0BAD_C0DE, 0, rd_v, er_v);
    issue(BASE + 32'h20, 2'b00, 2'b11, 1'b0, 32'hCAFE_F00D, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_req_ready", {31'h0, req_ready}, 32'h1);
    check("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    repeat (6) @(negedge clk);
    check("abort_quiet", {31'h0, resp_valid}, 32'h0);
    do_txn(BASE + 32'h20, 2'b11, 2'b00, 1'b0, 32'h0, 0, rd_v, er_v);
    check("lit_abort_prior", rd_v, 32'h0BAD_C0DE);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
